track_sequencer: RTL and testbench

TRACK_SEQUENCER -- requirements
Module: track_sequencer

---
 rtl/track_pkg.sv | 96 +++++++++
 rtl/ir_debounce.sv | 49 ++++
 rtl/track_sequencer.sv | 126 ++++++++++++
 tb/tb_track_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared definitions for the track sequencer.
// Contents:
//   - the sequencer state encoding (also driven out on seq_state for debug)
//   - timing constants (debounce length, launch length)
//   - the wheel duty and servo width constants
//   - helpers that classify the sensor pattern and map a state to its outputs
package track_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_STRAIGHT = 3'd2,
    ST_LEFT     = 3'd3,
    ST_RIGHT    = 3'd4,
    ST_CROSS    = 3'd5,
    ST_STOP     = 3'd6
  } seq_state_e;

  // Steering request decoded from the four line sensors.
  typedef enum logic [2:0] {
    PAT_STRAIGHT = 3'd0,
    PAT_CROSS    = 3'd1,
    PAT_LEFT     = 3'd2,
    PAT_RIGHT    = 3'd3,
    PAT_HOLD     = 3'd4
  } pattern_e;

  localparam int DEB_CYCLES    = 16;
  localparam int LAUNCH_FRAMES = 4;

  localparam logic [9:0]  DUTY_LAUNCH  = 10'd470;
  localparam logic [9:0]  DUTY_RUN     = 10'd50;
  localparam logic [9:0]  DUTY_SLOW    = 10'd30;
  localparam logic [9:0]  DUTY_STOP    = 10'd0;

  localparam logic [19:0] STEER_CENTER = 20'd70000;
  localparam logic [19:0] STEER_LEFT   = 20'd35000;
  localparam logic [19:0] STEER_RIGHT  = 20'd100000;

  function automatic pattern_e classify(input logic l, input logic ml,
                                        input logic mr, input logic r);
    logic lft;
    logic rgt;
    lft = l | ml;
    rgt = mr | r;
    if (!l && !ml && !mr && !r)     return PAT_STRAIGHT;
    else if (l && ml && mr && r)    return PAT_CROSS;
    else if (lft && !rgt)           return PAT_LEFT;
    else if (rgt && !lft)           return PAT_RIGHT;
    else                            return PAT_HOLD;
  endfunction

  // Tracking state selected by a pattern; an ambiguous pattern keeps hold_st.
  function automatic seq_state_e track_from(input pattern_e pat,
                                            input seq_state_e hold_st);
    case (pat)
      PAT_STRAIGHT: return ST_STRAIGHT;
      PAT_CROSS:    return ST_CROSS;
      PAT_LEFT:     return ST_LEFT;
      PAT_RIGHT:    return ST_RIGHT;
      default:      return hold_st;
    endcase
  endfunction

  // Servo width for a pattern while launching; ambiguous keeps the last width.
  function automatic logic [19:0] launch_steer(input pattern_e pat,
                                               input logic [19:0] last);
    case (pat)
      PAT_LEFT:     return STEER_LEFT;
      PAT_RIGHT:    return STEER_RIGHT;
      PAT_STRAIGHT,
      PAT_CROSS:    return STEER_CENTER;
      default:      return last;
    endcase
  endfunction

  function automatic logic [9:0] duty_of(input seq_state_e st);
    case (st)
      ST_LAUNCH:   return DUTY_LAUNCH;
      ST_STRAIGHT,
      ST_LEFT,
      ST_RIGHT:    return DUTY_RUN;
      ST_CROSS:    return DUTY_SLOW;
      default:     return DUTY_STOP;
    endcase
  endfunction

  function automatic logic [19:0] steer_of(input seq_state_e st);
    case (st)
      ST_LEFT:  return STEER_LEFT;
      ST_RIGHT: return STEER_RIGHT;
      default:  return STEER_CENTER;
    endcase
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchroniser followed by a debouncer for one asynchronous sensor.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (clears synchroniser, counter, output)
//   din   - raw asynchronous sensor input
//   dout  - accepted (debounced) value; changes only after DEB_CYCLES
//           consecutive synchronised samples that differ from it
module ir_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Because the signal is binary, "differs from the accepted value" on
  // consecutive samples means those samples are all equal to each other, so
  // a single run counter is enough; any sample matching dout restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      dout    <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // stage p1 -> dout: debounce
      if (sync_p1 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync_p1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/track_sequencer.sv
// Line-following sequencer: debounces five sensors and, once per PWM frame,
// picks a driving state and the matching rear-wheel duty and servo width.
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   ir_left, ir_mid_left, ir_mid_right, ir_right - line sensors (1 = line)
//   tail         - end-of-track marker sensor
//   frame_tick   - one-cycle pulse at the start of each PWM period
//   wheel_duty   - rear-wheel high time, counts out of 1000
//   steer_width  - servo high time in clk cycles
//   seq_state    - current state encoding, debug only
module track_sequencer
  import track_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_left,
  input  logic        ir_mid_left,
  input  logic        ir_mid_right,
  input  logic        ir_right,
  input  logic        tail,
  input  logic        frame_tick,
  output logic [9:0]  wheel_duty,
  output logic [19:0] steer_width,
  output logic [2:0]  seq_state
);

  logic l_db;
  logic ml_db;
  logic mr_db;
  logic r_db;
  logic tail_db;

  ir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .din(ir_left),      .dout(l_db));
  ir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_mid_left (
    .clk(clk), .rst_n(rst_n), .din(ir_mid_left),  .dout(ml_db));
  ir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_mid_right (
    .clk(clk), .rst_n(rst_n), .din(ir_mid_right), .dout(mr_db));
  ir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .din(ir_right),     .dout(r_db));
  ir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_tail (
    .clk(clk), .rst_n(rst_n), .din(tail),         .dout(tail_db));

  localparam logic [2:0] LAUNCH_LAST = 3'(LAUNCH_FRAMES - 1);

  seq_state_e  state;
  seq_state_e  state_nxt;
  logic [2:0]  launch_cnt;
  logic [2:0]  launch_cnt_nxt;
  logic [9:0]  duty_nxt;
  logic [19:0] steer_nxt;
  pattern_e    pat;

  assign pat       = classify(l_db, ml_db, mr_db, r_db);
  assign seq_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      launch_cnt  <= 3'd0;
      wheel_duty  <= DUTY_STOP;
      steer_width <= STEER_CENTER;
    end else begin
      state       <= state_nxt;
      launch_cnt  <= launch_cnt_nxt;
      wheel_duty  <= duty_nxt;
      steer_width <= steer_nxt;
    end
  end

  // Everything holds between frame ticks; decisions are made only on a tick.
  // launch_cnt is cleared on entry (the entry tick is frame 1), so the exit
  // happens on the tick that finds it at LAUNCH_FRAMES-1.
  always_comb begin
    state_nxt      = state;
    launch_cnt_nxt = launch_cnt;
    duty_nxt       = wheel_duty;
    steer_nxt      = steer_width;
    if (frame_tick) begin
      if (tail_db) begin
        state_nxt = ST_STOP;
        duty_nxt  = DUTY_STOP;
        steer_nxt = STEER_CENTER;
      end else begin
        case (state)
          ST_IDLE: begin
            state_nxt      = ST_LAUNCH;
            launch_cnt_nxt = 3'd0;
            duty_nxt       = DUTY_LAUNCH;
            steer_nxt      = launch_steer(pat, steer_width);
          end
          ST_LAUNCH: begin
            if (launch_cnt >= LAUNCH_LAST) begin
              // No tracking state exists yet, so an ambiguous pattern
              // falls back to STRAIGHT.
              state_nxt = track_from(pat, ST_STRAIGHT);
              duty_nxt  = duty_of(state_nxt);
              steer_nxt = steer_of(state_nxt);
            end else begin
              launch_cnt_nxt = (launch_cnt == 3'd7) ? launch_cnt
                                                    : launch_cnt + 3'd1;
              duty_nxt       = DUTY_LAUNCH;
              steer_nxt      = launch_steer(pat, steer_width);
            end
          end
          ST_STRAIGHT, ST_LEFT, ST_RIGHT, ST_CROSS: begin
            state_nxt = track_from(pat, state);
            duty_nxt  = duty_of(state_nxt);
            steer_nxt = steer_of(state_nxt);
          end
          ST_STOP: begin
            duty_nxt  = DUTY_STOP;
            steer_nxt = STEER_CENTER;
          end
          default: begin
            state_nxt = ST_IDLE;
            duty_nxt  = DUTY_STOP;
            steer_nxt = STEER_CENTER;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_track_sequencer.sv
module tb_track_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ir_left = 1'b0;
  logic        ir_mid_left = 1'b0;
  logic        ir_mid_right = 1'b0;
  logic        ir_right = 1'b0;
  logic        tail = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  wheel_duty;
  logic [19:0] steer_width;
  logic [2:0]  seq_state;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [9:0]  duty;
    logic [19:0] steer;
    logic [2:0]  st;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  track_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .ir_left(ir_left), .ir_mid_left(ir_mid_left),
    .ir_mid_right(ir_mid_right), .ir_right(ir_right),
    .tail(tail), .frame_tick(frame_tick),
    .wheel_duty(wheel_duty), .steer_width(steer_width), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: the output event is the clock edge after a sampled frame_tick.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick && rst_n) begin
        @(negedge clk);
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_output: got %0d/%0d/%0d, required no output",
                   wheel_duty, steer_width, seq_state);
        end else begin
          e = exp_q.pop_front();
          if (wheel_duty !== e.duty || steer_width !== e.steer || seq_state !== e.st) begin
            mismatched++;
            $display("FAIL %s: got duty/steer/state %0d/%0d/%0d, required %0d/%0d/%0d",
                     e.name, wheel_duty, steer_width, seq_state, e.duty, e.steer, e.st);
          end
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input string nm, input logic [9:0] d,
                      input logic [19:0] s, input logic [2:0] st);
    exp_t e;
    e.duty = d; e.steer = s; e.st = st; e.name = nm;
    exp_q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic frame(input string nm, input logic [9:0] d,
                       input logic [19:0] s, input logic [2:0] st);
    wait_cycles(999);
    tick(nm, d, s, st);
  endtask

  task automatic check_now(input string nm, input logic [9:0] d,
                           input logic [19:0] s, input logic [2:0] st);
    compared++;
    if (wheel_duty !== d || steer_width !== s || seq_state !== st) begin
      mismatched++;
      $display("FAIL %s: got duty/steer/state %0d/%0d/%0d, required %0d/%0d/%0d",
               nm, wheel_duty, steer_width, seq_state, d, s, st);
    end
  endtask

  task automatic set_ir(input logic l, input logic ml, input logic mr, input logic r);
    ir_left = l; ir_mid_left = ml; ir_mid_right = mr; ir_right = r;
  endtask

  initial begin : stimulus
    // Reset at time 2, before any clock edge: outputs must come from reset alone.
    #2 rst_n = 1'b0;
    #1 check_now("reset_state", 10'd0, 20'd70000, 3'd0);
    wait_cycles(3);
    rst_n = 1'b1;

    // Launch: four frames at 470, then STRAIGHT at 50, centred.
    frame("launch_f1", 10'd470, 20'd70000, 3'd1);
    frame("launch_f2", 10'd470, 20'd70000, 3'd1);
    frame("launch_f3", 10'd470, 20'd70000, 3'd1);
    frame("launch_f4", 10'd470, 20'd70000, 3'd1);
    frame("straight_after_launch", 10'd50, 20'd70000, 3'd2);

    // ir_left stable for 20 cycles before a tick -> LEFT.
    wait_cycles(500);
    set_ir(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(20);
    tick("left_20cyc", 10'd50, 20'd35000, 3'd3);

    set_ir(1'b0, 1'b0, 1'b0, 1'b1);
    frame("right_alone", 10'd50, 20'd100000, 3'd4);

    set_ir(1'b0, 1'b0, 1'b0, 1'b0);
    frame("back_straight", 10'd50, 20'd70000, 3'd2);

    // 10-cycle glitch on ir_mid_right is filtered out.
    wait_cycles(300);
    ir_mid_right = 1'b1;
    wait_cycles(10);
    ir_mid_right = 1'b0;
    wait_cycles(100);
    tick("glitch_filtered", 10'd50, 20'd70000, 3'd2);

    set_ir(1'b1, 1'b1, 1'b1, 1'b1);
    frame("cross", 10'd30, 20'd70000, 3'd5);
    set_ir(1'b1, 1'b1, 1'b0, 1'b1);
    frame("cross_held", 10'd30, 20'd70000, 3'd5);

    set_ir(1'b0, 1'b0, 1'b0, 1'b0);
    frame("straight_again", 10'd50, 20'd70000, 3'd2);
    set_ir(1'b1, 1'b0, 1'b0, 1'b0);
    frame("left_again", 10'd50, 20'd35000, 3'd3);

    // Outputs hold between ticks, then async reset mid-period in LEFT.
    wait_cycles(500);
    check_now("hold_between_ticks", 10'd50, 20'd35000, 3'd3);
    #2 rst_n = 1'b0;
    set_ir(1'b0, 1'b0, 1'b0, 1'b0);
    #1 check_now("async_reset_in_left", 10'd0, 20'd70000, 3'd0);
    wait_cycles(3);
    rst_n = 1'b1;

    // Tail during launch frame 2 -> sticky STOP.
    frame("relaunch_f1", 10'd470, 20'd70000, 3'd1);
    tail = 1'b1;
    frame("tail_stop", 10'd0, 20'd70000, 3'd6);
    tail = 1'b0;
    frame("stop_sticky_1", 10'd0, 20'd70000, 3'd6);
    frame("stop_sticky_2", 10'd0, 20'd70000, 3'd6);

    #2 rst_n = 1'b0;
    #1 check_now("reset_from_stop", 10'd0, 20'd70000, 3'd0);
    wait_cycles(3);
    rst_n = 1'b1;

    // A full launch repeats after reset.
    frame("post_stop_f1", 10'd470, 20'd70000, 3'd1);
    frame("post_stop_f2", 10'd470, 20'd70000, 3'd1);
    frame("post_stop_f3", 10'd470, 20'd70000, 3'd1);
    frame("post_stop_f4", 10'd470, 20'd70000, 3'd1);
    frame("post_stop_straight", 10'd50, 20'd70000, 3'd2);

    wait_cycles(5);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
